// File: rtl/dm_wait_ctrl_pkg.sv
// rtl/dm_wait_ctrl_pkg.sv - shared constants, state and size types for the wait-state data memory
package dm_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} dm_size_t;

  // Undefined funct3 codes fall through to word size.
  function automatic dm_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3_size(f3))
      SZ_B:    return 1'b0;
      SZ_H:    return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dm_wait_ctrl_if.sv
// rtl/dm_wait_ctrl_if.sv - core-to-data-memory request/response/stall bundle
interface dm_wait_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              stall;
  logic              misalign_err;
  logic [31:0]       perf_stall_cnt;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, stall, misalign_err, perf_stall_cnt
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, stall, misalign_err, perf_stall_cnt
  );
endinterface

// File: rtl/dm_wait_ctrl_sram.sv
// rtl/dm_wait_ctrl_sram.sv - word array with byte-enable synchronous write and combinational read
module dm_sram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/dm_wait_ctrl.sv
// rtl/dm_wait_ctrl.sv - data memory with programmable wait states, sub-word access and core stall
// Optional stall-cycle counter built only when DM_PERF_CNT_EN is defined.
module dm_wait_ctrl
  import dm_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter int                LATENCY     = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input logic           clk,
  input logic           rst,
  dm_wait_ctrl_if.slave bus
);
  localparam int                IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]        LAT4    = 4'(LATENCY);
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH_WORDS);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("dm_wait_ctrl: DATA_W must be 32");
  end
  if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("dm_wait_ctrl: LATENCY out of range");
  end
  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("dm_wait_ctrl: DEPTH_WORDS must be a power of two");
  end

  dm_state_t         state_q;
  logic [3:0]        cnt_q;
  logic              ready_q;
  logic              resp_valid_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic mis, accept;
  assign mis    = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
  assign accept = (state_q == IDLE) && bus.req_valid && !mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      we_q         <= 1'b0;
      f3_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= LAT4;
            ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q <= 4'd1) begin
            cnt_q        <= '0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end
      endcase
    end
  end

  // Decode is taken from the latched address so it is stable through WAIT/RESP.
  logic [ADDR_W-1:0] off, word_off;
  logic              in_range;
  assign off      = addr_q - BASE_ADDR;
  assign word_off = off >> 2;
  assign in_range = (addr_q >= BASE_ADDR) && (word_off < DEPTH_A);

  logic [3:0]  be;
  logic [31:0] wd;
  always_comb begin
    be = 4'hF;
    wd = wdata_q;
    case (f3_size(f3_q))
      SZ_B: begin
        be = 4'b0001 << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        be = addr_q[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_q[15:0]}};
      end
      default: begin
        be = 4'hF;
        wd = wdata_q;
      end
    endcase
  end

  logic [31:0] sram_rd;
  dm_sram #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_sram (
    .clk     (clk),
    .we_i    (resp_valid_q && we_q && in_range),
    .be_i    (be),
    .addr_i  (word_off[IDX_W-1:0]),
    .wdata_i (wd),
    .rdata_o (sram_rd)
  );

  logic [31:0] shifted, ext;
  assign shifted = sram_rd >> {addr_q[1:0], 3'b000};
  always_comb begin
    ext = shifted;
    case (f3_q)
      F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ext = {24'h0, shifted[7:0]};
      F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ext = {16'h0, shifted[15:0]};
      default: ext = sram_rd;
    endcase
  end

  assign bus.req_ready    = ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = (resp_valid_q && !we_q && in_range) ? ext : '0;
  assign bus.stall        = accept || (state_q == WAIT);
  assign bus.misalign_err = (state_q == IDLE) && bus.req_valid && mis;

`ifdef DM_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;
  always_comb begin
    perf_d = perf_q;
    if (bus.stall && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end
  assign bus.perf_stall_cnt = perf_q;
`else
  assign bus.perf_stall_cnt = '0;
`endif
endmodule
